// File: rtl/zxuno_clk_pkg.sv
// rtl/zxuno_clk_pkg.sv - CPU mode encodings and clamped enable-shift helper
package zxuno_clk_pkg;

  localparam logic [1:0] CPU_MODE_3M5 = 2'd0;
  localparam logic [1:0] CPU_MODE_7M  = 2'd1;
  localparam logic [1:0] CPU_MODE_14M = 2'd2;
  localparam logic [1:0] CPU_MODE_28M = 2'd3;

  // log2 of the CPU divide ratio for a mode, clamped at zero (enable every cycle)
  function automatic int ce_shift(input logic [1:0] mode, input int base);
    int s;
    s = base - int'(mode);
    return (s < 0) ? 0 : s;
  endfunction

endpackage

// File: rtl/ce_tap.sv
// rtl/ce_tap.sv - registered pulse when the low K+1 bits of the next count are all ones
module ce_tap #(
  parameter int K = 0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [K:0]   cnt_nxt_i,
  output logic         ce_o
);

  logic ce_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ce_q <= 1'b0;
    end else begin
      ce_q <= &cnt_nxt_i;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - free-running divider, divided-clock enables and glitch-free CPU turbo enable
module clock_enable_gen
  import zxuno_clk_pkg::*;
#(
  parameter int         DIVW       = 4,
  parameter int         BASE_SHIFT = 3,
  parameter logic [1:0] MODE_RESET = CPU_MODE_3M5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode_req,
  input  logic            cpu_stall,
  output logic [DIVW-1:0] clk_div,
  output logic [DIVW-1:0] ce_div,
  output logic            cpu_ce,
  output logic [1:0]      cur_mode,
  output logic            mode_busy
);

  if (DIVW < BASE_SHIFT) begin : g_param_check
    $error("clock_enable_gen: DIVW must be >= BASE_SHIFT");
  end

  // Common boundary of every mode period: low BASE_SHIFT bits all ones
  localparam logic [DIVW-1:0] BASE_MASK = DIVW'((1 << BASE_SHIFT) - 1);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [1:0]      cur_mode_q, cur_mode_d;
  logic            cpu_ce_q, cpu_ce_d;
  logic            mode_busy_q, mode_busy_d;
  logic [DIVW-1:0] cpu_mask;
  int              shift;

  always_comb begin
    cnt_d       = cnt_q + DIVW'(1);
    cur_mode_d  = cur_mode_q;
    if ((cnt_q & BASE_MASK) == BASE_MASK) begin
      cur_mode_d = mode_req;
    end
    mode_busy_d = (mode_req != cur_mode_d);
    // The enable for the next cycle follows the mode that will be in force then
    shift       = ce_shift(cur_mode_d, BASE_SHIFT);
    cpu_mask    = '0;
    for (int i = 0; i < DIVW; i++) begin
      cpu_mask[i] = (i < shift);
    end
    cpu_ce_d    = ((cnt_d & cpu_mask) == cpu_mask) & ~cpu_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cur_mode_q  <= MODE_RESET;
      cpu_ce_q    <= 1'b0;
      mode_busy_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_mode_q  <= cur_mode_d;
      cpu_ce_q    <= cpu_ce_d;
      mode_busy_q <= mode_busy_d;
    end
  end

  for (genvar k = 0; k < DIVW; k++) begin : g_tap
    ce_tap #(
      .K (k)
    ) u_ce_tap (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .cnt_nxt_i (cnt_d[k:0]),
      .ce_o      (ce_div[k])
    );
  end

  assign clk_div   = cnt_q;
  assign cpu_ce    = cpu_ce_q;
  assign cur_mode  = cur_mode_q;
  assign mode_busy = mode_busy_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb/tb_clock_enable_gen.sv - directed self-checking bench for clock_enable_gen
module tb_clock_enable_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_req = 2'd0;
  logic       cpu_stall = 1'b0;
  logic [3:0] clk_div;
  logic [3:0] ce_div;
  logic       cpu_ce;
  logic [1:0] cur_mode;
  logic       mode_busy;
  logic [7:0] obs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  clock_enable_gen #(
    .DIVW       (4),
    .BASE_SHIFT (3),
    .MODE_RESET (2'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_req  (mode_req),
    .cpu_stall (cpu_stall),
    .clk_div   (clk_div),
    .ce_div    (ce_div),
    .cpu_ce    (cpu_ce),
    .cur_mode  (cur_mode),
    .mode_busy (mode_busy)
  );

  // {clk_div, cpu_ce, cur_mode, mode_busy}
  assign obs = {clk_div, cpu_ce, cur_mode, mode_busy};

  task automatic step;
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_obs got=%h exp=00", obs);
    end
    checks++;
    if (ce_div !== 4'h0) begin
      errors++;
      $display("FAIL reset_ce_div got=%h exp=0", ce_div);
    end
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=00", obs);
    end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_counter;
    logic [7:0] exp;
    logic [3:0] e_div;
    for (int n = 0; n < 64; n++) begin
      for (int k = 0; k < 4; k++) e_div[k] = ((cyc % (2 << k)) == ((2 << k) - 1));
      exp = {cyc[3:0], (cyc % 8 == 7), 2'd0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL counter cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      checks++;
      if (ce_div !== e_div) begin
        errors++;
        $display("FAIL ce_div cyc=%0d got=%h exp=%h", cyc, ce_div, e_div);
      end
      step();
    end
  endtask

  task automatic test_turbo;
    int base, rel;
    logic [7:0] exp;
    logic       e_ce, e_busy;
    logic [1:0] e_mode;
    while (cyc % 8 != 0) step();
    base = cyc;
    mode_req = 2'd3;
    for (int n = 0; n < 40; n++) begin
      step();
      rel    = cyc - base;
      e_mode = (rel >= 8 && rel < 32) ? 2'd3 : 2'd0;
      e_busy = (rel >= 1 && rel <= 7) || (rel >= 25 && rel <= 31);
      e_ce   = (rel < 7) ? 1'b0 : (rel < 32) ? 1'b1 : (rel % 8 == 7);
      exp    = {cyc[3:0], e_ce, e_mode, e_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL turbo rel=%0d got=%h exp=%h", rel, obs, exp);
      end
      if (rel == 24) mode_req = 2'd0;
    end
  endtask

  task automatic test_switch;
    int base, rel;
    logic [7:0] exp;
    logic       e_ce, e_busy;
    logic [1:0] e_mode;
    while (cyc % 8 != 1) step();
    base = cyc - 1;
    mode_req = 2'd2;
    for (int n = 0; n < 39; n++) begin
      step();
      rel    = cyc - base;
      e_mode = (rel >= 8 && rel < 32) ? 2'd2 : 2'd0;
      e_busy = (rel >= 2 && rel <= 7) || (rel >= 25 && rel <= 31);
      e_ce   = (rel < 8) ? (rel == 7) : (rel < 32) ? (rel % 2 == 1) : (rel % 8 == 7);
      exp    = {cyc[3:0], e_ce, e_mode, e_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL switch_0_2 rel=%0d got=%h exp=%h", rel, obs, exp);
      end
      if (rel == 24) mode_req = 2'd0;
    end
  endtask

  task automatic test_toggle;
    int base, rel;
    logic [7:0] exp;
    while (cyc % 8 != 0) step();
    base = cyc;
    for (int n = 0; n < 24; n++) begin
      step();
      rel = cyc - base;
      exp = {cyc[3:0], (rel % 8 == 7), 2'd0, (rel >= 2 && rel <= 4)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL toggle rel=%0d got=%h exp=%h", rel, obs, exp);
      end
      if (rel == 1) mode_req = 2'd1;
      if (rel == 4) mode_req = 2'd0;
    end
  endtask

  task automatic test_stall;
    int base, rel;
    logic [7:0] exp;
    while (cyc % 16 != 5) step();
    base = cyc - 5;
    cpu_stall = 1'b1;
    for (int n = 0; n < 26; n++) begin
      step();
      rel = cyc - base;
      if (rel == 10) cpu_stall = 1'b0;
      exp = {cyc[3:0], ((rel % 8 == 7) && (rel != 7)), 2'd0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stall rel=%0d got=%h exp=%h", rel, obs, exp);
      end
      checks++;
      if (ce_div[0] !== (rel % 2 == 1)) begin
        errors++;
        $display("FAIL stall_ce_div0 rel=%0d got=%b exp=%b", rel, ce_div[0], (rel % 2 == 1));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp;
    while (cyc % 16 != 9) step();
    mode_req = 2'd3;
    step();
    checks++;
    if (obs !== {4'd10, 1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL pending_busy got=%h exp=%h", obs, {4'd10, 1'b0, 2'd0, 1'b1});
    end
    step();
    checks++;
    if (ce_div !== 4'b0011) begin
      errors++;
      $display("FAIL pre_reset_ce_div got=%h exp=3", ce_div);
    end
    rst_n = 1'b0;
    mode_req = 2'd0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%h exp=00", obs);
    end
    checks++;
    if (ce_div !== 4'h0) begin
      errors++;
      $display("FAIL async_reset_ce_div got=%h exp=0", ce_div);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_held got=%h exp=00", obs);
    end
    rst_n = 1'b1;
    cyc = 0;
    for (int n = 0; n < 20; n++) begin
      exp = {cyc[3:0], (cyc % 8 == 7), 2'd0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_turbo();
    test_switch();
    test_toggle();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
